// File: rtl/decompress_16b40b_pkg.sv
// Shared constants, FSM encoding and payload types for the 16b->40b BFP expander.
package decompress_16b40b_pkg;

    localparam int unsigned NUM       = 16;
    localparam int unsigned OW        = 40;
    localparam int unsigned PKT_LEN   = 24;
    localparam int unsigned SHIFT_MAX = 24;
    localparam int unsigned SW        = 5;
    localparam int unsigned CW        = 6;
    localparam int unsigned PAD       = OW - NUM;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_e;

    typedef struct packed {
        logic       sel;
        logic [6:0] slot_idx;
        logic [3:0] symb_idx;
        logic [8:0] prb_idx;
        logic [3:0] ch_type;
        logic [7:0] info;
    } side_t;

    typedef struct packed {
        logic shift_err;
        logic len_err;
        logic frm_err;
    } err_t;

    // Exponents beyond the all-zero point behave as the all-zero exponent.
    function automatic logic [SW-1:0] clamp_shift(input logic [SW-1:0] s);
        return (32'(s) > SHIFT_MAX) ? SW'(SHIFT_MAX) : s;
    endfunction

endpackage

// File: rtl/decompress_16b40b_bfp_expand_lane.sv
// One registered component expander: sext({m, zeros}) >>> shift.
module bfp_expand_lane
    import decompress_16b40b_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NUM-1:0]  i_m,
    input  logic [SW-1:0]   i_shift,
    output logic [OW-1:0]   o_dout
);

    logic signed [OW-1:0] ext;
    logic        [OW-1:0] dout_d;
    logic        [OW-1:0] dout_q;

    // Left-justify the mantissa, then shift back down keeping the sign.
    always_comb begin
        ext    = {i_m, {PAD{1'b0}}};
        dout_d = OW'(ext >>> i_shift);
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign o_dout = dout_q;

endmodule

// File: rtl/decompress_16b40b.sv
// Block-floating-point expander: 16b I/Q mantissas + per-packet exponent -> 40b I/Q.
module decompress_16b40b
    import decompress_16b40b_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_sel,
    input  logic              i_sop,
    input  logic              i_eop,
    input  logic              i_vld,
    input  logic [2*NUM-1:0]  i_din,
    input  logic [SW-1:0]     i_shift,
    input  logic [6:0]        i_slot_idx,
    input  logic [3:0]        i_symb_idx,
    input  logic [8:0]        i_prb_idx,
    input  logic [3:0]        i_ch_type,
    input  logic [7:0]        i_info,
    output logic              o_sel,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_vld,
    output logic [2*OW-1:0]   o_dout,
    output logic [6:0]        o_slot_idx,
    output logic [3:0]        o_symb_idx,
    output logic [8:0]        o_prb_idx,
    output logic [3:0]        o_type,
    output logic [7:0]        o_info,
    output logic              o_shift_err,
    output logic              o_len_err,
    output logic              o_frm_err
);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SW-1:0]      lat_q, lat_d;
    logic [SW-1:0]      sh_clamp;
    logic [CW:0]        cnt_inc;

    logic               s1_vld_q, s1_vld_d;
    logic               s1_sop_q, s1_sop_d;
    logic               s1_eop_q, s1_eop_d;
    logic [2*NUM-1:0]   s1_din_q, s1_din_d;
    logic [SW-1:0]      s1_shift_q, s1_shift_d;
    side_t              s1_side_q, s1_side_d;
    err_t               s1_err_q, s1_err_d;

    logic               s2_vld_q, s2_vld_d;
    logic               s2_sop_q, s2_sop_d;
    logic               s2_eop_q, s2_eop_d;
    side_t              s2_side_q, s2_side_d;
    err_t               s2_err_q, s2_err_d;

    logic [OW-1:0]      dout_i, dout_q;

    // Packet framing FSM, beat counter, exponent latch and error detection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        s1_err_d = '0;
        sh_clamp = clamp_shift(i_shift);
        cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
        if (i_vld) begin
            if (i_sop) begin
                lat_d              = sh_clamp;
                s1_err_d.shift_err = (32'(i_shift) > SHIFT_MAX);
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_sop && i_eop) begin
                        s1_err_d.len_err = (PKT_LEN != 32'd1);
                        cnt_d            = '0;
                    end else if (i_sop) begin
                        cnt_d   = CW'(1);
                        state_d = ST_IN_PKT;
                    end else begin
                        s1_err_d.frm_err = 1'b1;
                    end
                end
                ST_IN_PKT: begin
                    if (i_sop) begin
                        s1_err_d.frm_err = 1'b1;
                        if (i_eop) begin
                            s1_err_d.len_err = (PKT_LEN != 32'd1);
                            cnt_d            = '0;
                            state_d          = ST_IDLE;
                        end else begin
                            cnt_d = CW'(1);
                        end
                    end else if (i_eop) begin
                        s1_err_d.len_err = (cnt_inc != (CW+1)'(PKT_LEN));
                        cnt_d            = '0;
                        state_d          = ST_IDLE;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Stage 1 capture: controls qualified by valid, effective exponent selected.
    always_comb begin
        s1_vld_d   = i_vld;
        s1_sop_d   = i_sop & i_vld;
        s1_eop_d   = i_eop & i_vld;
        s1_din_d   = i_din;
        s1_shift_d = (i_vld && i_sop) ? sh_clamp : lat_q;
        s1_side_d  = '{sel: i_sel, slot_idx: i_slot_idx, symb_idx: i_symb_idx,
                       prb_idx: i_prb_idx, ch_type: i_ch_type, info: i_info};
    end

    // Stage 2 capture of everything that does not go through the lanes.
    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_sop_d  = s1_sop_q;
        s2_eop_d  = s1_eop_q;
        s2_side_d = s1_side_q;
        s2_err_d  = s1_err_q;
    end

    // Control state and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lat_q      <= SW'(SHIFT_MAX);
            s1_vld_q   <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_din_q   <= '0;
            s1_shift_q <= '0;
            s1_side_q  <= '0;
            s1_err_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
            s2_side_q  <= '0;
            s2_err_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            s1_vld_q   <= s1_vld_d;
            s1_sop_q   <= s1_sop_d;
            s1_eop_q   <= s1_eop_d;
            s1_din_q   <= s1_din_d;
            s1_shift_q <= s1_shift_d;
            s1_side_q  <= s1_side_d;
            s1_err_q   <= s1_err_d;
            s2_vld_q   <= s2_vld_d;
            s2_sop_q   <= s2_sop_d;
            s2_eop_q   <= s2_eop_d;
            s2_side_q  <= s2_side_d;
            s2_err_q   <= s2_err_d;
        end
    end

    bfp_expand_lane u_lane_i (
        .clk     (clk),
        .rst     (rst),
        .i_m     (s1_din_q[2*NUM-1:NUM]),
        .i_shift (s1_shift_q),
        .o_dout  (dout_i)
    );

    bfp_expand_lane u_lane_q (
        .clk     (clk),
        .rst     (rst),
        .i_m     (s1_din_q[NUM-1:0]),
        .i_shift (s1_shift_q),
        .o_dout  (dout_q)
    );

    assign o_dout      = {dout_i, dout_q};
    assign o_vld       = s2_vld_q;
    assign o_sop       = s2_sop_q;
    assign o_eop       = s2_eop_q;
    assign o_sel       = s2_side_q.sel;
    assign o_slot_idx  = s2_side_q.slot_idx;
    assign o_symb_idx  = s2_side_q.symb_idx;
    assign o_prb_idx   = s2_side_q.prb_idx;
    assign o_type      = s2_side_q.ch_type;
    assign o_info      = s2_side_q.info;
    assign o_shift_err = s2_err_q.shift_err;
    assign o_len_err   = s2_err_q.len_err;
    assign o_frm_err   = s2_err_q.frm_err;

endmodule

// File: tb/tb_decompress_16b40b.sv
// Self-checking bench for decompress_16b40b: vector table + scoreboard + framing sequences.
module tb_decompress_16b40b;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sel, i_sop, i_eop, i_vld;
    logic [31:0] i_din;
    logic [4:0]  i_shift;
    logic [6:0]  i_slot_idx;
    logic [3:0]  i_symb_idx;
    logic [8:0]  i_prb_idx;
    logic [3:0]  i_ch_type;
    logic [7:0]  i_info;
    logic        o_sel, o_sop, o_eop, o_vld;
    logic [79:0] o_dout;
    logic [6:0]  o_slot_idx;
    logic [3:0]  o_symb_idx;
    logic [8:0]  o_prb_idx;
    logic [3:0]  o_type;
    logic [7:0]  o_info;
    logic        o_shift_err, o_len_err, o_frm_err;

    decompress_16b40b dut (
        .clk(clk), .rst(rst), .i_sel(i_sel), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
        .i_din(i_din), .i_shift(i_shift), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
        .i_prb_idx(i_prb_idx), .i_ch_type(i_ch_type), .i_info(i_info),
        .o_sel(o_sel), .o_sop(o_sop), .o_eop(o_eop), .o_vld(o_vld), .o_dout(o_dout),
        .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_prb_idx(o_prb_idx),
        .o_type(o_type), .o_info(o_info), .o_shift_err(o_shift_err),
        .o_len_err(o_len_err), .o_frm_err(o_frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] dout;
        logic        sop, eop;
        logic [32:0] side;
        logic [2:0]  err;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [4:0]  sh;
        logic [31:0] din;
        logic [79:0] exp_dout;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_serr = 0, n_lerr = 0, n_ferr = 0;
    int   s0, l0, f0;

    bit   m_in_pkt;
    int   m_cnt;
    int   m_lat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: scale by 2^24 in 64-bit signed arithmetic, then shift.
    function automatic logic [39:0] exp_lane(input logic [15:0] m, input int s);
        longint v;
        v = longint'($signed(m));
        v = v * 64'sd16777216;
        v = v >>> s;
        return v[39:0];
    endfunction

    function automatic logic [32:0] cur_side();
        return {i_sel, i_slot_idx, i_symb_idx, i_prb_idx, i_ch_type, i_info};
    endfunction

    // Framing model: predicts error pulses and the exponent each beat decodes with.
    task automatic model_push(input bit sop, input bit eop, input int sh, input bit use_ovr,
                              input logic [79:0] ovr);
        exp_t e;
        bit   serr, lerr, ferr;
        serr = sop && (sh > 24);
        lerr = 1'b0;
        ferr = 1'b0;
        if (sop) m_lat = (sh > 24) ? 24 : sh;
        if (!m_in_pkt) begin
            if (sop && eop) lerr = 1'b1;          // packet length is 24, not 1
            else if (sop) begin m_cnt = 1; m_in_pkt = 1'b1; end
            else ferr = 1'b1;
        end else begin
            if (sop) begin
                ferr = 1'b1;
                if (eop) begin lerr = 1'b1; m_in_pkt = 1'b0; m_cnt = 0; end
                else m_cnt = 1;
            end else if (eop) begin
                lerr = (m_cnt + 1 != 24);
                m_in_pkt = 1'b0;
                m_cnt = 0;
            end else if (m_cnt < 63) begin
                m_cnt++;
            end
        end
        e.dout = use_ovr ? ovr : {exp_lane(i_din[31:16], m_lat), exp_lane(i_din[15:0], m_lat)};
        e.sop  = sop;
        e.eop  = eop;
        e.side = cur_side();
        e.err  = {serr, lerr, ferr};
        e.cyc  = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic randomize_side();
        i_sel      = 1'($urandom);
        i_slot_idx = 7'($urandom);
        i_symb_idx = 4'($urandom);
        i_prb_idx  = 9'($urandom);
        i_ch_type  = 4'($urandom);
        i_info     = 8'($urandom);
    endtask

    task automatic send_gap();
        @(negedge clk);
        i_vld   = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        i_din   = $urandom;
        i_shift = 5'($urandom);
        randomize_side();
    endtask

    // Non-sop beats carry a random exponent, which must be ignored.
    task automatic send_beat(input bit sop, input bit eop, input logic [4:0] sh,
                             input logic [31:0] din, input bit use_ovr, input logic [79:0] ovr);
        @(negedge clk);
        i_vld   = 1'b1;
        i_sop   = sop;
        i_eop   = eop;
        i_din   = din;
        i_shift = sop ? sh : 5'($urandom);
        randomize_side();
        model_push(sop, eop, int'(i_shift), use_ovr, ovr);
    endtask

    task automatic send_pkt(input int n, input logic [4:0] sh, input int restart_at, input bit gaps);
        for (int b = 1; b <= n; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) send_gap();
            send_beat((b == 1) || (b == restart_at), b == n, (b == restart_at) ? 5'd6 : sh,
                      $urandom, 1'b0, 80'h0);
        end
    endtask

    task automatic flush();
        send_gap();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("flush_pending", 128'(sb.size()), 128'd0);
    endtask

    task automatic snap();
        s0 = n_serr; l0 = n_lerr; f0 = n_ferr;
    endtask

    task automatic chk_errs(input string name, input int es, input int el, input int ef);
        chk({name, "_shift_err_cnt"}, 128'(n_serr - s0), 128'(es));
        chk({name, "_len_err_cnt"},   128'(n_lerr - l0), 128'(el));
        chk({name, "_frm_err_cnt"},   128'(n_ferr - f0), 128'(ef));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_dout"}, 128'(o_dout), 128'd0);
        chk({name, "_ctl"}, 128'({o_sel, o_sop, o_eop, o_vld, o_shift_err, o_len_err, o_frm_err}), 128'd0);
        chk({name, "_side"}, 128'({o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}), 128'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every valid output beat.
    always @(posedge clk) begin
        #1;
        n_serr += int'(o_shift_err);
        n_lerr += int'(o_len_err);
        n_ferr += int'(o_frm_err);
        if (o_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_vld", 128'd1, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("dout", 128'(o_dout), 128'(mon_e.dout));
                chk("sop_eop", 128'({o_sop, o_eop}), 128'({mon_e.sop, mon_e.eop}));
                chk("side", 128'({o_sel, o_slot_idx, o_symb_idx, o_prb_idx, o_type, o_info}),
                    128'(mon_e.side));
                chk("errs", 128'({o_shift_err, o_len_err, o_frm_err}), 128'(mon_e.err));
                chk("latency", 128'(cyc), 128'(mon_e.cyc));
            end
        end else begin
            chk("idle_ctl", 128'({o_sop, o_eop, o_shift_err, o_len_err, o_frm_err}), 128'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        vt[0] = '{5'd0,  32'h7FFF_8000, 80'h7F_FF00_0000_80_0000_0000};
        vt[1] = '{5'd8,  32'h0001_FFFF, 80'h00_0001_0000_FF_FFFF_0000};
        vt[2] = '{5'd24, 32'h1234_8000, 80'h00_0000_1234_FF_FFFF_8000};
        vt[3] = '{5'd27, 32'h1234_FFFF, 80'h00_0000_1234_FF_FFFF_FFFF};

        rst = 1'b1;
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_din = '0; i_shift = '0;
        i_sel = 1'b0; i_slot_idx = '0; i_symb_idx = '0; i_prb_idx = '0; i_ch_type = '0; i_info = '0;
        m_in_pkt = 1'b0; m_cnt = 0; m_lat = 24;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Extremes and exponent limits: each vector is the sop beat of a clean packet.
        snap();
        for (int v = 0; v < 4; v++) begin
            send_beat(1'b1, 1'b0, vt[v].sh, vt[v].din, 1'b1, vt[v].exp_dout);
            for (int b = 2; b <= 24; b++) send_beat(1'b0, b == 24, 5'd0, $urandom, 1'b0, 80'h0);
        end
        flush();
        chk_errs("vectors", 1, 0, 0);

        // Two clean packets with random gaps.
        snap();
        send_pkt(24, 5'd3, 0, 1'b1);
        send_pkt(24, 5'd10, 0, 1'b1);
        flush();
        chk_errs("clean_pkts", 0, 0, 0);

        // Short packet: eop on beat 20.
        snap();
        send_pkt(20, 5'd4, 0, 1'b1);
        flush();
        chk_errs("short_pkt", 0, 1, 0);

        // Restart on beat 5, then 24 beats from the restart.
        snap();
        send_pkt(28, 5'd2, 5, 1'b1);
        flush();
        chk_errs("restart", 0, 0, 1);

        // Data beats in IDLE, the last one carrying eop.
        snap();
        send_beat(1'b0, 1'b0, 5'd0, $urandom, 1'b0, 80'h0);
        send_beat(1'b0, 1'b0, 5'd0, $urandom, 1'b0, 80'h0);
        send_beat(1'b0, 1'b1, 5'd0, $urandom, 1'b0, 80'h0);
        flush();
        chk_errs("idle_beats", 0, 0, 3);

        // Reset on beat 10, then a clean packet.
        snap();
        send_pkt(9, 5'd7, 0, 1'b0);
        send_pkt(0, 5'd0, 0, 1'b0);
        for (int b = 2; b <= 9; b++) begin end
        @(negedge clk);
        rst = 1'b1;
        i_vld = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_din = $urandom;
        sb.delete();
        m_in_pkt = 1'b0; m_cnt = 0; m_lat = 24;
        @(posedge clk);
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        i_vld = 1'b0;
        send_pkt(24, 5'd5, 0, 1'b1);
        flush();
        chk_errs("after_reset", 0, 0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
